// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter: captures a WIDTH-bit word on load and shifts it out one bit per BIT_DIV clocks.
// Optional even-parity trailer bit enabled by defining PISO_TX_PARITY_EN.
module piso_tx #(
    parameter int WIDTH     = 3,
    parameter int BIT_DIV   = 50_000_000,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] pi,
    output logic             so,
    output logic             bit_stb,
    output logic             busy,
    output logic             done
);

`ifdef PISO_TX_PARITY_EN
    localparam int FRAME = WIDTH + 1;
`else
    localparam int FRAME = WIDTH;
`endif
    localparam int DIV_W = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
    localparam int CNT_W = $clog2(WIDTH + 2);
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(BIT_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(FRAME - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state_r, state_s;
    logic [WIDTH-1:0]   shreg_r, shreg_s;
    logic [DIV_W-1:0]   div_r, div_s;
    logic [CNT_W-1:0]   cnt_r, cnt_s;
    logic               so_r, so_s;
    logic               bit_stb_r, bit_stb_s;
    logic               busy_r, busy_s;
    logic               done_r, done_s;
    logic               data_bit_s;

`ifdef PISO_TX_PARITY_EN
    logic               par_r, par_s;

    function automatic logic even_parity(input logic [WIDTH-1:0] word);
        return ^word;
    endfunction
`endif

    // State, datapath and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            shreg_r   <= {WIDTH{1'b0}};
            div_r     <= {DIV_W{1'b0}};
            cnt_r     <= {CNT_W{1'b0}};
            so_r      <= 1'b0;
            bit_stb_r <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
`ifdef PISO_TX_PARITY_EN
            par_r     <= 1'b0;
`endif
        end else begin
            state_r   <= state_s;
            shreg_r   <= shreg_s;
            div_r     <= div_s;
            cnt_r     <= cnt_s;
            so_r      <= so_s;
            bit_stb_r <= bit_stb_s;
            busy_r    <= busy_s;
            done_r    <= done_s;
`ifdef PISO_TX_PARITY_EN
            par_r     <= par_s;
`endif
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_s = state_r;
        shreg_s = shreg_r;
        div_s   = div_r;
        cnt_s   = cnt_r;
`ifdef PISO_TX_PARITY_EN
        par_s   = par_r;
`endif
        case (state_r)
            IDLE: begin
                if (load) begin
                    state_s = SHIFT;
                    shreg_s = pi;
                    div_s   = {DIV_W{1'b0}};
                    cnt_s   = {CNT_W{1'b0}};
`ifdef PISO_TX_PARITY_EN
                    par_s   = even_parity(pi);
`endif
                end else begin
                    state_s = IDLE;
                end
            end
            SHIFT: begin
                if (div_r == DIV_LAST) begin
                    div_s   = {DIV_W{1'b0}};
                    cnt_s   = cnt_r + CNT_W'(1);
                    shreg_s = MSB_FIRST ? (shreg_r << 1'b1) : (shreg_r >> 1'b1);
                    if (cnt_r == CNT_LAST) begin
                        state_s = DONE;
                    end else begin
                        state_s = SHIFT;
                    end
                end else begin
                    div_s = div_r + DIV_W'(1);
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Outputs are derived from the next state so that they appear registered in the same cycle as the state.
    always_comb begin
        so_s       = 1'b0;
        bit_stb_s  = 1'b0;
        busy_s     = 1'b0;
        done_s     = 1'b0;
        data_bit_s = MSB_FIRST ? shreg_s[WIDTH-1] : shreg_s[0];
        if (state_s == SHIFT) begin
            busy_s    = 1'b1;
            bit_stb_s = (div_s == DIV_LAST);
`ifdef PISO_TX_PARITY_EN
            so_s      = (cnt_s == CNT_W'(WIDTH)) ? par_s : data_bit_s;
`else
            so_s      = data_bit_s;
`endif
        end else begin
            done_s = (state_s == DONE);
        end
    end

    assign so      = so_r;
    assign bit_stb = bit_stb_r;
    assign busy    = busy_r;
    assign done    = done_r;

endmodule

// File: tb/tb_piso_tx.sv
// Self-checking bench for piso_tx: three instances (MSB-first, LSB-first, BIT_DIV=1) checked against a timing model every cycle.
module tb_piso_tx;

    localparam int D = 4;
`ifdef PISO_TX_PARITY_EN
    localparam int FRAME = 4;
`else
    localparam int FRAME = 3;
`endif

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic       load_a = 1'b0, load_b = 1'b0, load_c = 1'b0;
    logic [2:0] pi_a = 3'b000, pi_b = 3'b000, pi_c = 3'b000;
    logic       so_a, stb_a, busy_a, done_a;
    logic       so_b, stb_b, busy_b, done_b;
    logic       so_c, stb_c, busy_c, done_c;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    piso_tx #(.WIDTH(3), .BIT_DIV(D), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .rst_n(rst_n), .load(load_a), .pi(pi_a),
        .so(so_a), .bit_stb(stb_a), .busy(busy_a), .done(done_a));
    piso_tx #(.WIDTH(3), .BIT_DIV(D), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rst_n(rst_n), .load(load_b), .pi(pi_b),
        .so(so_b), .bit_stb(stb_b), .busy(busy_b), .done(done_b));
    piso_tx #(.WIDTH(3), .BIT_DIV(1), .MSB_FIRST(1'b1)) u_div1 (
        .clk(clk), .rst_n(rst_n), .load(load_c), .pi(pi_c),
        .so(so_c), .bit_stb(stb_c), .busy(busy_c), .done(done_c));

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [3:0] got, input logic [3:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%h want=%h", name, cyc, got, exp);
        end
    endtask

    // Frame model: one accepted load at cycle t0 fixes every output for the following cycles.
    bit         act_a = 1'b0, act_b = 1'b0, act_c = 1'b0;
    int         t_a = 0, t_b = 0, t_c = 0;
    logic [2:0] w_a = 3'b000, w_b = 3'b000, w_c = 3'b000;

    function automatic bit accepts(bit act, int t0, int d, int c);
        return !act || (c >= t0 + FRAME * d + 2);
    endfunction

    function automatic logic [3:0] expect_out(bit act, int t0, int d, bit msb, logic [2:0] w, int c);
        int k;
        logic [2:0] sh;
        logic b;
        if (!act) return 4'b0000;
        if (c >= t0 + 1 && c <= t0 + FRAME * d) begin
            k = (c - t0 - 1) / d;
            if (k < 3) begin
                sh = w >> (msb ? (2 - k) : k);
                b  = sh[0];
            end else begin
                b = ^w;
            end
            return {b, ((c - t0) % d) == 0, 1'b1, 1'b0};
        end
        if (c == t0 + FRAME * d + 1) return 4'b0001;
        return 4'b0000;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_a <= 1'b0; act_b <= 1'b0; act_c <= 1'b0;
        end else begin
            if (load_a && accepts(act_a, t_a, D, cyc)) begin act_a <= 1'b1; t_a <= cyc; w_a <= pi_a; end
            if (load_b && accepts(act_b, t_b, D, cyc)) begin act_b <= 1'b1; t_b <= cyc; w_b <= pi_b; end
            if (load_c && accepts(act_c, t_c, 1, cyc)) begin act_c <= 1'b1; t_c <= cyc; w_c <= pi_c; end
        end
    end

    task automatic cmp(input string tag, input logic [3:0] got, input logic [3:0] exp);
        check({tag, "_so"},   {3'b000, got[3]}, {3'b000, exp[3]});
        check({tag, "_stb"},  {3'b000, got[2]}, {3'b000, exp[2]});
        check({tag, "_busy"}, {3'b000, got[1]}, {3'b000, exp[1]});
        check({tag, "_done"}, {3'b000, got[0]}, {3'b000, exp[0]});
    endtask

    always @(negedge clk) begin
        cmp("m_msb",  {so_a, stb_a, busy_a, done_a}, expect_out(act_a, t_a, D, 1'b1, w_a, cyc));
        cmp("m_lsb",  {so_b, stb_b, busy_b, done_b}, expect_out(act_b, t_b, D, 1'b0, w_b, cyc));
        cmp("m_div1", {so_c, stb_c, busy_c, done_c}, expect_out(act_c, t_c, 1, 1'b1, w_c, cyc));
    end

    // Receiving SIPO for the LSB-first instance, clocked on bit_stb, data bits only.
    int         nstb_b = 0;
    logic [2:0] rx_b = 3'b000;
    always @(posedge clk) begin
        if (load_b) begin
            nstb_b <= 0;
        end else if (stb_b) begin
            if (nstb_b < 3) rx_b <= {so_b, rx_b[2:1]};
            nstb_b <= nstb_b + 1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog cycle=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_so",   {3'b000, so_a},   4'h0);
        check("rst_busy", {3'b000, busy_a}, 4'h0);
        check("rst_done", {3'b000, done_a}, 4'h0);
        check("rst_stb",  {3'b000, stb_a},  4'h0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Frame 1 on all instances; a second load at t+5 must be ignored.
        load_a = 1'b1; pi_a = 3'b101;
        load_b = 1'b1; pi_b = 3'b110;
        load_c = 1'b1; pi_c = 3'b111;
        for (int o = 1; o <= FRAME * D + 1; o++) begin
            @(negedge clk);
            load_a = (o == 5);
            pi_a   = (o == 5) ? 3'b000 : 3'($urandom);
            load_b = 1'b0; pi_b = 3'($urandom);
            load_c = 1'b0; pi_c = 3'($urandom);
            if (o == 1) begin
                check("f1_so_first",  {3'b000, so_a},   4'h1);
                check("f1_busy",      {3'b000, busy_a}, 4'h1);
                check("f1_lsb_first", {3'b000, so_b},   4'h0);
                check("f1_div1_so",   {3'b000, so_c},   4'h1);
                check("f1_div1_stb",  {3'b000, stb_c},  4'h1);
            end
            if (o == 4) begin
                check("f1_stb_t4", {3'b000, stb_a}, 4'h1);
                check("f1_so_t4",  {3'b000, so_a},  4'h1);
            end
            if (o == 5) begin
                check("f1_so_t5",  {3'b000, so_a},  4'h0);
                check("f1_stb_t5", {3'b000, stb_a}, 4'h0);
            end
            if (o == 9) check("f1_so_t9", {3'b000, so_a}, 4'h1);
`ifdef PISO_TX_PARITY_EN
            if (o == 5)  check("f1_div1_done", {3'b000, done_c}, 4'h1);
            if (o == 13) begin
                check("f1_par_so",   {3'b000, so_a},   4'h0);
                check("f1_par_busy", {3'b000, busy_a}, 4'h1);
            end
            if (o == 17) check("f1_done", {3'b000, done_a}, 4'h1);
`else
            if (o == 4) check("f1_div1_done", {3'b000, done_c}, 4'h1);
            if (o == 13) begin
                check("f1_done",      {3'b000, done_a}, 4'h1);
                check("f1_busy_done", {3'b000, busy_a}, 4'h0);
            end
`endif
        end
        check("sipo_rx", {1'b0, rx_b}, 4'h6);

        // Earliest accepted next load, then an asynchronous reset mid-frame.
        @(negedge clk);
        load_a = 1'b1; pi_a = 3'b110;
        for (int o = 1; o <= 6; o++) begin
            @(negedge clk);
            load_a = 1'b0;
            if (o == 1) begin
                check("f2_so_first", {3'b000, so_a},   4'h1);
                check("f2_busy",     {3'b000, busy_a}, 4'h1);
            end
            if (o == 6) check("f2_so_t6", {3'b000, so_a}, 4'h1);
        end
        #2 rst_n = 1'b0;
        #1;
        check("arst_so",   {3'b000, so_a},   4'h0);
        check("arst_busy", {3'b000, busy_a}, 4'h0);
        check("arst_stb",  {3'b000, stb_a},  4'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        load_a = 1'b1; pi_a = 3'b011;
        for (int o = 1; o <= FRAME * D + 2; o++) begin
            @(negedge clk);
            load_a = 1'b0;
            if (o == 1) check("f3_so_first", {3'b000, so_a}, 4'h0);
            if (o == 5) check("f3_so_t5",    {3'b000, so_a}, 4'h1);
            if (o == FRAME * D + 1) check("f3_done", {3'b000, done_a}, 4'h1);
        end

`ifdef PISO_TX_PARITY_EN
        load_a = 1'b1; pi_a = 3'b100;
        for (int o = 1; o <= FRAME * D + 2; o++) begin
            @(negedge clk);
            load_a = 1'b0;
            if (o == 13) check("p1_so_t13",  {3'b000, so_a},   4'h1);
            if (o == 16) check("p1_stb_t16", {3'b000, stb_a},  4'h1);
            if (o == 17) check("p1_done",    {3'b000, done_a}, 4'h1);
        end
        load_a = 1'b1; pi_a = 3'b110;
        for (int o = 1; o <= FRAME * D + 2; o++) begin
            @(negedge clk);
            load_a = 1'b0;
            if (o == 13) begin
                check("p2_so_t13",   {3'b000, so_a},   4'h0);
                check("p2_busy_t13", {3'b000, busy_a}, 4'h1);
            end
        end
`endif

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
